bcd_to_bin_seq: RTL and testbench

Sequential reverse-double-dabble converter from 4-digit packed BCD (0–9999) to unsigned binary. It is the inverse of the existing combinational binary-to-BCD path. It lets keypad, switch or display-entry values in decimal digits feed arithmetic datapaths. A conversion is launched with a single-cycle start and is reported with a one-cycle done pulse. The block also flags any non-decimal digit it receives.

---
 rtl/bcd_pkg.sv | 22 ++
 rtl/bcd_nib_sub3.sv | 12 +
 rtl/bcd_to_bin_seq.sv | 101 ++++++++++
 tb/tb_bcd_to_bin_seq.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the sequential BCD-to-binary converter.
// Digit legality check lives here so every user agrees on what "decimal" means.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int BCD_DIGIT_MAX = 9;
  localparam int BCD_DIGITS    = 4;
  localparam int BCD_W         = 4 * BCD_DIGITS;
  localparam int BCD_CORR      = 3;
  localparam int BCD_CORR_MIN  = 8;
  localparam int BIN_W_MIN     = 14;

  function automatic logic digit_bad(input logic [3:0] d);
    return d > 4'(BCD_DIGIT_MAX);
  endfunction

endpackage

// File: rtl/bcd_nib_sub3.sv
// Per-digit correction for reverse double-dabble: a nibble that reached 8 or more
// after the right shift was a 10s-carry from the digit above, so it drops by 3.
module bcd_nib_sub3
  import bcd_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= 4'(BCD_CORR_MIN)) ? d - 4'(BCD_CORR) : d;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential 4-digit BCD to binary converter (reverse double-dabble), one shift per cycle.
// Launched by a single-cycle start in IDLE; reports with a one-cycle done and an err flag.
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W = BIN_W_MIN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       thousands,
  input  logic [3:0]       hundreds,
  input  logic [3:0]       tens,
  input  logic [3:0]       ones,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [BIN_W-1:0] binary
);

  localparam int WORK_W = BCD_W + BIN_W;
  localparam int CNT_W  = $clog2(BIN_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  state_t              state, state_nxt;
  logic [WORK_W-1:0]   w_reg;
  logic [WORK_W-1:0]   w_shift;
  logic [WORK_W-1:0]   w_next;
  logic [CNT_W-1:0]    cnt;
  logic                digits_bad;
  logic                last_iter;

  assign digits_bad = digit_bad(thousands) | digit_bad(hundreds) |
                      digit_bad(tens) | digit_bad(ones);
  assign last_iter  = (cnt == CNT_LAST);

  // One iteration: shift the whole work register right, then correct each BCD nibble
  assign w_shift = w_reg >> 1;
  assign w_next[BIN_W-1:0] = w_shift[BIN_W-1:0];

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_nib
    bcd_nib_sub3 u_nib (
      .d (w_shift[BIN_W + 4*g +: 4]),
      .q (w_next[BIN_W + 4*g +: 4])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = digits_bad ? DONE : SHIFT;
      end
      SHIFT: begin
        if (last_iter) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Datapath and result registers; digits are captured only on acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_reg  <= '0;
      cnt    <= '0;
      err    <= 1'b0;
      binary <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            w_reg <= {thousands, hundreds, tens, ones, {BIN_W{1'b0}}};
            cnt   <= '0;
            if (digits_bad) begin
              err    <= 1'b1;
              binary <= '0;
            end else begin
              err <= 1'b0;
            end
          end
        end
        SHIFT: begin
          w_reg <= w_next;
          if (last_iter) binary <= w_next[BIN_W-1:0];
          else           cnt    <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Randomised self-checking bench for bcd_to_bin_seq against a decimal-arithmetic reference.
`timescale 1ns/1ps
module tb_bcd_to_bin_seq;

  localparam int BIN_W = 14;
  localparam int LAT   = BIN_W;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [3:0]       thousands, hundreds, tens, ones;
  logic             busy, done, err;
  logic [BIN_W-1:0] binary;

  int total = 0;
  int bad   = 0;

  bcd_to_bin_seq #(.BIN_W(BIN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .thousands (thousands),
    .hundreds  (hundreds),
    .tens      (tens),
    .ones      (ones),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .binary    (binary)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: binary value to packed BCD by decimal arithmetic
  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  // Reference: packed BCD digits to expected (value, err)
  function automatic void ref_conv(input logic [15:0] d, output int val, output logic e);
    e   = (d[15:12] > 9) || (d[11:8] > 9) || (d[7:4] > 9) || (d[3:0] > 9);
    val = e ? 0 : (int'(d[15:12]) * 1000 + int'(d[11:8]) * 100 + int'(d[7:4]) * 10 + int'(d[3:0]));
  endfunction

  // Drives one request and gathers observations; comparisons are done by the callers
  task automatic do_conv(input logic [15:0] d, output int lat, output logic ok,
                         output logic e, output logic [BIN_W-1:0] b,
                         output logic [15:0] bcdf, output logic busy0,
                         output logic busy_after, output logic done_after);
    {thousands, hundreds, tens, ones} = d;
    start = 1'b1;
    tick();
    start = 1'b0;
    busy0 = busy;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    ok   = (done === 1'b1);
    e    = err;
    b    = binary;
    bcdf = dut.w_reg[BIN_W +: 16];
    tick();
    busy_after = busy;
    done_after = done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    {thousands, hundreds, tens, ones} = 16'h0;
    tick();
    tick();
    total++;
    if ({busy, done, err, binary} !== {3'b000, {BIN_W{1'b0}}}) begin
      bad++;
      $display("FAIL reset_in: busy=%b done=%b err=%b binary=%0d required all zero", busy, done, err, binary);
    end
    rst_n = 1'b1;
    tick();
    tick();
    total++;
    if ({busy, done, err, binary} !== {3'b000, {BIN_W{1'b0}}}) begin
      bad++;
      $display("FAIL reset_out: busy=%b done=%b err=%b binary=%0d required all zero", busy, done, err, binary);
    end
  endtask

  task automatic test_zero();
    int lat; logic ok, e, b0, ba, da; logic [BIN_W-1:0] b; logic [15:0] f;
    do_conv(16'h0000, lat, ok, e, b, f, b0, ba, da);
    total++;
    if (!ok || lat !== LAT) begin
      bad++;
      $display("FAIL zero_latency: done seen=%b after %0d edges, required %0d", ok, lat, LAT);
    end
    total++;
    if (b !== 0 || e !== 1'b0) begin
      bad++;
      $display("FAIL zero_result: binary=%0d err=%b required 0/0", b, e);
    end
    total++;
    if (b0 !== 1'b1 || ba !== 1'b0 || da !== 1'b0) begin
      bad++;
      $display("FAIL zero_handshake: busy_start=%b busy_after=%b done_after=%b required 1/0/0", b0, ba, da);
    end
  endtask

  task automatic test_max();
    int lat; logic ok, e, b0, ba, da; logic [BIN_W-1:0] b; logic [15:0] f;
    do_conv(16'h9999, lat, ok, e, b, f, b0, ba, da);
    total++;
    if (!ok || b !== 14'h270F || e !== 1'b0) begin
      bad++;
      $display("FAIL max_result: done=%b binary=%0d err=%b required 9999 err 0", ok, b, e);
    end
    total++;
    if (f !== 16'h0) begin
      bad++;
      $display("FAIL max_bcd_zero: bcd field=%h required 0000", f);
    end
  endtask

  task automatic test_invalid();
    int lat; logic ok, e, b0, ba, da; logic [BIN_W-1:0] b; logic [15:0] f;
    do_conv(16'h10A3, lat, ok, e, b, f, b0, ba, da);
    total++;
    if (!ok || lat !== 0 || e !== 1'b1 || b !== 0) begin
      bad++;
      $display("FAIL invalid_digit: done=%b lat=%0d err=%b binary=%0d required 1/0/1/0", ok, lat, e, b);
    end
    total++;
    if (ba !== 1'b0 || da !== 1'b0) begin
      bad++;
      $display("FAIL invalid_return: busy_after=%b done_after=%b required 0/0", ba, da);
    end
    do_conv(16'h0010, lat, ok, e, b, f, b0, ba, da);
    total++;
    if (!ok || b !== 10 || e !== 1'b0) begin
      bad++;
      $display("FAIL after_invalid: binary=%0d err=%b required 10 err 0", b, e);
    end
  endtask

  task automatic test_roundtrip();
    int lat; logic ok, e, b0, ba, da; logic [BIN_W-1:0] b; logic [15:0] f;
    for (int v = 0; v < 4096; v++) begin
      do_conv(to_bcd(v), lat, ok, e, b, f, b0, ba, da);
      total++;
      if (!ok || int'(b) != v || e !== 1'b0 || f !== 16'h0 || lat != LAT) begin
        bad++;
        $display("FAIL roundtrip v=%0d: binary=%0d err=%b bcd=%h lat=%0d required %0d/0/0000/%0d",
                 v, b, e, f, lat, v, LAT);
      end
    end
  endtask

  task automatic test_random();
    int lat, exp_v; logic ok, e, b0, ba, da, exp_e; logic [BIN_W-1:0] b; logic [15:0] f, d;
    for (int i = 0; i < 60; i++) begin
      for (int k = 0; k < 4; k++)
        d[4*k +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      ref_conv(d, exp_v, exp_e);
      do_conv(d, lat, ok, e, b, f, b0, ba, da);
      total++;
      if (!ok || int'(b) != exp_v || e !== exp_e || lat != (exp_e ? 0 : LAT)) begin
        bad++;
        $display("FAIL random digits=%h: binary=%0d err=%b lat=%0d required %0d/%b/%0d",
                 d, b, e, lat, exp_v, exp_e, exp_e ? 0 : LAT);
      end
    end
  endtask

  task automatic test_ignored_start();
    int ndone = 0;
    logic [BIN_W-1:0] b = '0;
    {thousands, hundreds, tens, ones} = 16'h4095;
    start = 1'b1;
    tick();
    for (int c = 1; c <= 30; c++) begin
      if (c == 3 || c == 8) begin
        {thousands, hundreds, tens, ones} = 16'h1111;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      if (done === 1'b1) begin
        ndone++;
        b = binary;
      end
    end
    start = 1'b0;
    total++;
    if (ndone != 1 || b !== 14'd4095) begin
      bad++;
      $display("FAIL ignored_start: dones=%0d binary=%0d required 1 and 4095", ndone, b);
    end
  endtask

  task automatic test_reset_abort();
    int ndone = 0;
    int lat; logic ok, e, b0, ba, da; logic [BIN_W-1:0] b; logic [15:0] f;
    {thousands, hundreds, tens, ones} = 16'h1234;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 7; c++) tick();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, err, binary} !== {3'b000, {BIN_W{1'b0}}}) begin
      bad++;
      $display("FAIL abort_reset: busy=%b done=%b err=%b binary=%0d required all zero", busy, done, err, binary);
    end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) ndone++;
    end
    total++;
    if (ndone != 0) begin
      bad++;
      $display("FAIL abort_no_done: %0d active cycles after reset, required 0", ndone);
    end
    do_conv(16'h1234, lat, ok, e, b, f, b0, ba, da);
    total++;
    if (!ok || b !== 14'd1234 || e !== 1'b0 || lat != LAT) begin
      bad++;
      $display("FAIL abort_next: binary=%0d err=%b lat=%0d required 1234/0/%0d", b, e, lat, LAT);
    end
  endtask

  task automatic test_back_to_back();
    int vals[3];
    int n = 0;
    int last = 0;
    for (int i = 0; i < 3; i++) vals[i] = $urandom_range(0, 9999);
    {thousands, hundreds, tens, ones} = to_bcd(vals[0]);
    start = 1'b1;
    tick();
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (done === 1'b1) begin
        total++;
        if (n >= 3 || int'(binary) != vals[n] || (c - last) != (n == 0 ? LAT : LAT + 2)) begin
          bad++;
          $display("FAIL back_to_back #%0d: binary=%0d spacing=%0d required %0d spacing %0d",
                   n, binary, c - last, (n < 3) ? vals[n] : -1, n == 0 ? LAT : LAT + 2);
        end
        last = c;
        n++;
        if (n < 3) {thousands, hundreds, tens, ones} = to_bcd(vals[n]);
      end
    end
    start = 1'b0;
    for (int c = 0; c < 20; c++) tick();
    total++;
    if (n != 3) begin
      bad++;
      $display("FAIL back_to_back_count: dones=%0d required 3", n);
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_max();
    test_invalid();
    test_random();
    test_ignored_start();
    test_reset_abort();
    test_back_to_back();
    test_roundtrip();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
